// File: rtl/stopwatch_input_conditioner_pkg.sv
// stopwatch_input_conditioner_pkg: shared defaults and channel indices for the input conditioner
package stopwatch_input_conditioner_pkg;
  localparam int CLK_FREQ_HZ     = 100_000_000;
  localparam int DB_CYCLES_DEF   = 1_000_000;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int N_CH            = 4;
  localparam int CH_PAUSE        = 0;
  localparam int CH_RST          = 1;
  localparam int CH_SELECT       = 2;
  localparam int CH_ADJUST       = 3;
endpackage

// File: rtl/stopwatch_input_conditioner_if.sv
// stopwatch_input_conditioner_if: raw board inputs in, conditioned stopwatch controls out
interface stopwatch_input_conditioner_if;
  logic btn_pause;
  logic btn_rst;
  logic sw_select;
  logic sw_adjust;
  logic pause;
  logic rst_level;
  logic rst_pulse;
  logic select;
  logic adjust;
  modport master (
    output btn_pause, btn_rst, sw_select, sw_adjust,
    input  pause, rst_level, rst_pulse, select, adjust
  );
  modport slave (
    input  btn_pause, btn_rst, sw_select, sw_adjust,
    output pause, rst_level, rst_pulse, select, adjust
  );
endinterface

// File: rtl/debounce_channel.sv
// debounce_channel: synchroniser chain plus stable-count debouncer with rising-edge detect
module debounce_channel
  import stopwatch_input_conditioner_pkg::*;
#(
  parameter int DB_CYCLES   = DB_CYCLES_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise
);
  localparam int CW = $clog2(DB_CYCLES);
  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   stable_q, stable_d, prev_q;
  logic                   sync_bit, differ, done;
  assign sync_bit = sync_q[SYNC_STAGES-1];
  assign differ   = sync_bit != stable_q;
  assign done     = cnt_q == CW'(DB_CYCLES - 1);
  always_comb begin
    cnt_d    = (!differ || done) ? '0 : cnt_q + CW'(1);
    stable_d = (differ && done) ? sync_bit : stable_q;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
      prev_q   <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], din};
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      prev_q   <= stable_q;
    end
  end
  assign level = stable_q;
  assign rise  = stable_q & ~prev_q;
endmodule

// File: rtl/stopwatch_input_conditioner.sv
// stopwatch_input_conditioner: debounces board inputs and derives pause toggle and reset pulse
module stopwatch_input_conditioner
  import stopwatch_input_conditioner_pkg::*;
#(
  parameter int DB_CYCLES   = DB_CYCLES_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  stopwatch_input_conditioner_if.slave  bus
);
  logic [N_CH-1:0] din, level, rise;
  logic pause_q, pause_d, rst_level_q, rst_pulse_q, select_q, adjust_q;
  logic unused_ch;
  assign din = {bus.sw_adjust, bus.sw_select, bus.btn_rst, bus.btn_pause};
  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    debounce_channel #(.DB_CYCLES(DB_CYCLES), .SYNC_STAGES(SYNC_STAGES)) u_ch (
      .clk  (clk),
      .rst  (rst),
      .din  (din[c]),
      .level(level[c]),
      .rise (rise[c])
    );
  end
  assign unused_ch = level[CH_PAUSE] ^ rise[CH_SELECT] ^ rise[CH_ADJUST];
  // A held reset button dominates, so a coincident pause press cannot toggle
  always_comb begin
    pause_d = level[CH_RST] ? 1'b0 : rise[CH_PAUSE] ? ~pause_q : pause_q;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      pause_q     <= 1'b0;
      rst_level_q <= 1'b0;
      rst_pulse_q <= 1'b0;
      select_q    <= 1'b0;
      adjust_q    <= 1'b0;
    end else begin
      pause_q     <= pause_d;
      rst_level_q <= level[CH_RST];
      rst_pulse_q <= rise[CH_RST];
      select_q    <= level[CH_SELECT];
      adjust_q    <= level[CH_ADJUST];
    end
  end
  assign bus.pause     = pause_q;
  assign bus.rst_level = rst_level_q;
  assign bus.rst_pulse = rst_pulse_q;
  assign bus.select    = select_q;
  assign bus.adjust    = adjust_q;
endmodule
